// File: rtl/pov_char_pkg.sv
// Shared types and constants for the POV character buffer path.
package pov_char_pkg;

    localparam int CHAR_W_DEFAULT = 7;
    localparam logic [CHAR_W_DEFAULT-1:0] ASCII_SPACE = 7'h20;

    typedef logic [CHAR_W_DEFAULT-1:0] char_t;

endpackage

// File: rtl/pov_char_buffer_if.sv
// Host/renderer-facing signal bundle of the character buffer.
interface pov_char_buffer_if
    import pov_char_pkg::*;
#(
    parameter int CHAR_W = CHAR_W_DEFAULT,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
);

    logic              LoadChar;
    logic [CHAR_W-1:0] Ascii;
    logic              Clear;
    logic              Loop;
    logic              NextChar;
    logic              New;
    logic [CHAR_W-1:0] Char;
    logic [CNT_W-1:0]  Count;
    logic              Full;
    logic              Empty;
    logic              Overflow;
    logic              Wrap;

    modport master (
        output LoadChar, Ascii, Clear, Loop, NextChar,
        input  New, Char, Count, Full, Empty, Overflow, Wrap
    );

    modport slave (
        input  LoadChar, Ascii, Clear, Loop, NextChar,
        output New, Char, Count, Full, Empty, Overflow, Wrap
    );

endinterface

// File: rtl/pov_char_buffer_char_ram.sv
// Character storage: register array, synchronous write, asynchronous read.
module char_ram #(
    parameter int CHAR_W = 7,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              i_wrEn,
    input  logic [AW-1:0]     i_wrAddr,
    input  logic [CHAR_W-1:0] i_wrData,
    input  logic [AW-1:0]     i_rdAddr,
    output logic [CHAR_W-1:0] o_rdData
);

    logic [CHAR_W-1:0] r_mem [DEPTH];

    // No reset on the array: contents are only meaningful behind the pointers.
    always_ff @(posedge Clock) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/pov_char_buffer.sv
// Character message buffer feeding the POV column renderer; supports
// consume (FIFO) playback and circular loop replay of the stored message.
module pov_char_buffer
    import pov_char_pkg::*;
#(
    parameter int CHAR_W = CHAR_W_DEFAULT,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input logic             Clock,
    input logic             Reset,
    pov_char_buffer_if.slave bus
);

    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW-1:0]     r_po;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic              r_new;
    logic              r_wrap;
    logic [CHAR_W-1:0] r_char;

    logic              w_flush;
    logic              w_write;
    logic              w_read;
    logic              w_consume;
    logic              w_loopRead;
    logic              w_lastPo;
    logic [AW-1:0]     w_rdAddr;
    logic [CHAR_W-1:0] w_rdData;
    logic [CNT_W-1:0]  w_countNext;

    // Full/Empty come from registered state, so a same-cycle read never
    // frees space for a write.
    always_comb begin
        w_flush     = Reset || bus.Clear;
        w_write     = bus.LoadChar && !r_full && !w_flush;
        w_read      = bus.NextChar && !r_empty;
        w_consume   = w_read && !bus.Loop;
        w_loopRead  = w_read && bus.Loop;
        w_lastPo    = (CNT_W'(r_po) == (r_count - CNT_W'(1)));
        w_rdAddr    = r_rp + (bus.Loop ? r_po : '0);
        w_countNext = r_count + CNT_W'(w_write) - CNT_W'(w_consume);
    end

    char_ram #(
        .CHAR_W (CHAR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .Clock    (Clock),
        .i_wrEn   (w_write),
        .i_wrAddr (r_wp),
        .i_wrData (bus.Ascii),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge Clock) begin
        if (w_flush) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_po       <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_new      <= 1'b0;
            r_wrap     <= 1'b0;
            r_char     <= '0;
        end else begin
            r_new  <= w_read;
            r_wrap <= w_loopRead && w_lastPo;
            if (w_read) begin
                r_char <= w_rdData;
            end
            if (w_write) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_consume) begin
                r_rp <= r_rp + AW'(1);
            end
            // Leaving loop mode rewinds the play offset so consumption restarts at the head.
            if (!bus.Loop) begin
                r_po <= '0;
            end else if (w_loopRead) begin
                r_po <= w_lastPo ? '0 : r_po + AW'(1);
            end
            r_count <= w_countNext;
            r_full  <= (w_countNext == CNT_W'(DEPTH));
            r_empty <= (w_countNext == '0);
            if (bus.LoadChar && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.New      = r_new;
    assign bus.Char     = r_char;
    assign bus.Count    = r_count;
    assign bus.Full     = r_full;
    assign bus.Empty    = r_empty;
    assign bus.Overflow = r_overflow;
    assign bus.Wrap     = r_wrap;

endmodule

// File: tb/tb_pov_char_buffer.sv
// Scoreboard bench for pov_char_buffer with DEPTH = 4.
module tb_pov_char_buffer;
    import pov_char_pkg::*;

    localparam int DEPTH = 4;

    logic clock;
    logic reset;

    pov_char_buffer_if #(.CHAR_W(7), .DEPTH(DEPTH)) bus ();

    pov_char_buffer #(
        .CHAR_W (7),
        .DEPTH  (DEPTH)
    ) dut (
        .Clock (clock),
        .Reset (reset),
        .bus   (bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    char_t mdl[$];
    int    mdlPo = 0;
    char_t expCharQ[$];
    bit    expWrapQ[$];
    bit    expNew;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one cycle, advances the reference model and queues any expected read.
    task automatic applyStimulus(input bit load, input char_t a, input bit next);
        bit    full;
        bit    empty;
        bit    wrap;
        char_t c;
        full  = (mdl.size() == DEPTH);
        empty = (mdl.size() == 0);
        bus.LoadChar = load;
        bus.Ascii    = a;
        bus.NextChar = next;
        expNew = 1'b0;
        if (reset || bus.Clear) begin
            mdl.delete();
            mdlPo = 0;
        end else begin
            if (!bus.Loop) mdlPo = 0;
            if (next && !empty) begin
                expNew = 1'b1;
                if (bus.Loop) begin
                    c     = mdl[mdlPo];
                    wrap  = (mdlPo == mdl.size() - 1);
                    mdlPo = wrap ? 0 : mdlPo + 1;
                end else begin
                    c    = mdl.pop_front();
                    wrap = 1'b0;
                end
                expCharQ.push_back(c);
                expWrapQ.push_back(wrap);
            end
            if (load && !full) mdl.push_back(a);
        end
        @(posedge clock);
        #1;
        bus.LoadChar = 1'b0;
        bus.NextChar = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 7'h00, 1'b0);
        reset = 1'b0;
        nChecks++; if (bus.Count !== 3'd0) begin nFails++; $display("[TB] FAIL reset_count got %0d want 0", bus.Count); end
        nChecks++; if (bus.Empty !== 1'b1 || bus.Full !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flags empty=%b full=%b want 1/0", bus.Empty, bus.Full); end
        nChecks++; if (bus.Overflow !== 1'b0 || bus.Wrap !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ovf_wrap got %b/%b want 0/0", bus.Overflow, bus.Wrap); end
        applyStimulus(1'b0, 7'h00, 1'b1);
        nChecks++; if (bus.New !== 1'b0 || bus.Char !== 7'h00) begin nFails++; $display("[TB] FAIL empty_read new=%b char=%h want 0/00", bus.New, bus.Char); end
        nChecks++; if (bus.Empty !== 1'b1 || bus.Count !== 3'd0) begin nFails++; $display("[TB] FAIL empty_read_state empty=%b count=%0d want 1/0", bus.Empty, bus.Count); end
    endtask

    task automatic test_consume();
        char_t e;
        bit    w;
        bus.Loop = 1'b0;
        applyStimulus(1'b1, 7'h48, 1'b0);
        applyStimulus(1'b1, 7'h49, 1'b0);
        nChecks++; if (bus.Count !== 3'd2) begin nFails++; $display("[TB] FAIL consume_count got %0d want 2", bus.Count); end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 7'h00, 1'b1);
            nChecks++; if (bus.New !== expNew) begin nFails++; $display("[TB] FAIL consume_new got %b want %b", bus.New, expNew); end
            if (expNew) begin
                e = expCharQ.pop_front(); w = expWrapQ.pop_front();
                nChecks++; if (bus.Char !== e || bus.Wrap !== w) begin nFails++; $display("[TB] FAIL consume_char got %h/%b want %h/%b", bus.Char, bus.Wrap, e, w); end
            end
        end
        nChecks++; if (bus.Count !== 3'd0 || bus.Empty !== 1'b1) begin nFails++; $display("[TB] FAIL consume_drained count=%0d empty=%b want 0/1", bus.Count, bus.Empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, char_t'(7'h30 + i), 1'b0);
            if (i == 3) begin
                nChecks++; if (bus.Full !== 1'b1 || bus.Overflow !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_full full=%b ovf=%b want 1/0", bus.Full, bus.Overflow); end
            end
        end
        nChecks++; if (bus.Overflow !== 1'b1 || bus.Count !== 3'd4) begin nFails++; $display("[TB] FAIL ovf_set ovf=%b count=%0d want 1/4", bus.Overflow, bus.Count); end
        applyStimulus(1'b0, 7'h00, 1'b0);
        nChecks++; if (bus.Overflow !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_sticky got %b want 1", bus.Overflow); end
        bus.Clear = 1'b1;
        applyStimulus(1'b0, 7'h00, 1'b0);
        bus.Clear = 1'b0;
        nChecks++; if (bus.Count !== 3'd0 || bus.Overflow !== 1'b0 || bus.Empty !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_clear count=%0d ovf=%b empty=%b want 0/0/1", bus.Count, bus.Overflow, bus.Empty); end
    endtask

    task automatic test_loop();
        char_t e;
        bit    w;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, char_t'(7'h41 + i), 1'b0);
        bus.Loop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 7'h00, 1'b1);
            nChecks++; if (bus.New !== expNew) begin nFails++; $display("[TB] FAIL loop_new got %b want %b", bus.New, expNew); end
            if (expNew) begin
                e = expCharQ.pop_front(); w = expWrapQ.pop_front();
                nChecks++; if (bus.Char !== e || bus.Wrap !== w) begin nFails++; $display("[TB] FAIL loop_char[%0d] got %h/%b want %h/%b", i, bus.Char, bus.Wrap, e, w); end
            end
        end
        nChecks++; if (bus.Count !== 3'd3) begin nFails++; $display("[TB] FAIL loop_count got %0d want 3", bus.Count); end
        applyStimulus(1'b0, 7'h00, 1'b0);
        nChecks++; if (bus.New !== 1'b0 || bus.Wrap !== 1'b0 || bus.Char !== 7'h43) begin nFails++; $display("[TB] FAIL loop_idle new=%b wrap=%b char=%h want 0/0/43", bus.New, bus.Wrap, bus.Char); end
    endtask

    task automatic test_back_to_back();
        char_t e;
        bit    w;
        bus.Loop  = 1'b0;
        bus.Clear = 1'b1;
        applyStimulus(1'b0, 7'h00, 1'b0);
        bus.Clear = 1'b0;
        applyStimulus(1'b1, 7'h78, 1'b0);
        applyStimulus(1'b1, 7'h79, 1'b0);
        applyStimulus(1'b1, 7'h7a, 1'b1);
        nChecks++; if (bus.Count !== 3'd2) begin nFails++; $display("[TB] FAIL simul_count got %0d want 2", bus.Count); end
        applyStimulus(1'b1, 7'h61, 1'b0);
        applyStimulus(1'b1, 7'h62, 1'b0);
        nChecks++; if (bus.Full !== 1'b1) begin nFails++; $display("[TB] FAIL simul_full got %b want 1", bus.Full); end
        applyStimulus(1'b1, 7'h63, 1'b1);
        nChecks++; if (bus.Overflow !== 1'b1 || bus.Count !== 3'(DEPTH - 1)) begin nFails++; $display("[TB] FAIL simul_drop ovf=%b count=%0d want 1/3", bus.Overflow, bus.Count); end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 7'h00, 1'b1);
        nChecks++; if (expCharQ.size() != 5) begin nFails++; $display("[TB] FAIL simul_reads queued %0d want 5", expCharQ.size()); end
        // Only the most recent read is visible on Char; earlier ones are checked by order of New.
        while (expCharQ.size() > 1) begin e = expCharQ.pop_front(); w = expWrapQ.pop_front(); end
        e = expCharQ.pop_front(); w = expWrapQ.pop_front();
        nChecks++; if (bus.Char !== e || e !== 7'h62) begin nFails++; $display("[TB] FAIL simul_last got %h want %h", bus.Char, e); end
        nChecks++; if (bus.Empty !== 1'b1) begin nFails++; $display("[TB] FAIL simul_empty got %b want 1", bus.Empty); end
    endtask

    task automatic test_mode_switch();
        char_t e;
        bit    w;
        bus.Clear = 1'b1;
        applyStimulus(1'b0, 7'h00, 1'b0);
        bus.Clear = 1'b0;
        bus.Loop  = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, char_t'(7'h44 + i), 1'b0);
        applyStimulus(1'b0, 7'h00, 1'b1);
        applyStimulus(1'b0, 7'h00, 1'b1);
        e = expCharQ.pop_front(); w = expWrapQ.pop_front();
        e = expCharQ.pop_front(); w = expWrapQ.pop_front();
        nChecks++; if (bus.Char !== e || e !== 7'h45) begin nFails++; $display("[TB] FAIL switch_po2 got %h want %h", bus.Char, e); end
        bus.Loop = 1'b0;
        applyStimulus(1'b0, 7'h00, 1'b1);
        e = expCharQ.pop_front(); w = expWrapQ.pop_front();
        nChecks++; if (bus.Char !== e || e !== 7'h44 || bus.New !== 1'b1) begin nFails++; $display("[TB] FAIL switch_oldest got %h/%b want %h/1", bus.Char, bus.New, e); end
        nChecks++; if (bus.Count !== 3'd2) begin nFails++; $display("[TB] FAIL switch_count got %0d want 2", bus.Count); end
        bus.Loop = 1'b1;
        reset    = 1'b1;
        applyStimulus(1'b1, 7'h55, 1'b1);
        reset    = 1'b0;
        nChecks++; if (bus.New !== 1'b0 || bus.Char !== 7'h00 || bus.Wrap !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_out new=%b char=%h wrap=%b want 0/00/0", bus.New, bus.Char, bus.Wrap); end
        nChecks++; if (bus.Count !== 3'd0 || bus.Empty !== 1'b1 || bus.Full !== 1'b0 || bus.Overflow !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_state count=%0d empty=%b full=%b ovf=%b", bus.Count, bus.Empty, bus.Full, bus.Overflow); end
    endtask

    initial begin
        reset        = 1'b0;
        bus.LoadChar = 1'b0;
        bus.Ascii    = '0;
        bus.Clear    = 1'b0;
        bus.Loop     = 1'b0;
        bus.NextChar = 1'b0;
        test_reset();
        test_consume();
        test_overflow();
        test_loop();
        test_back_to_back();
        test_mode_switch();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pov_char_buffer.md
# pov_char_buffer

Parametrised character message buffer for the POV display path. It stores up to DEPTH characters written by the host/UART side and hands them one at a time to the column renderer, pulsing New with each character. It has two playback modes: consume (FIFO) and loop (circular replay of the stored message for a continuously spinning display).

## Interface
Parameters:
- CHAR_W, 7, character code width in bits (7 = ASCII).
- DEPTH, 16, storage entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), derived; width of Count.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- LoadChar  in  1  write strobe; Ascii is stored when asserted.
- Ascii  in  CHAR_W  character to store.
- Clear  in  1  synchronous flush of contents and flags.
- Loop  in  1  1 = circular replay, 0 = consume.
- NextChar  in  1  renderer request for the next character.
- New  out  1  one-cycle pulse: Char updated this cycle.
- Char  out  CHAR_W  current character; holds between updates.
- Count  out  CNT_W  number of stored characters.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Overflow  out  1  sticky: a write was dropped while Full.
- Wrap  out  1  one-cycle pulse with New when loop playback returns to the first character.

## Operation
- Storage: DEPTH×CHAR_W array. The block keeps these pointers, all modulo DEPTH:
  - wp: write pointer.
  - rp: head pointer.
  - po: play offset, range 0..Count-1.
- Priority, highest first: Reset, then Clear, then normal operation.
- Reset: pointers, po and Count = 0; Char = 0; New = 0; Wrap = 0; Overflow = 0; Full = 0; Empty = 1.
- Clear: same values as Reset. Memory contents are don't-care.
- Write, LoadChar && !Full:
  - mem[wp] = Ascii; wp++; Count++.
  - Full is evaluated on the registered Count. A write while Full is dropped even if a consume read happens in the same cycle, and Overflow is set.
- Consume mode (Loop = 0), NextChar && !Empty:
  - Char = mem[rp]; rp++; Count--; New = 1.
  - po is forced to 0 every cycle in this mode.
- Loop mode (Loop = 1), NextChar && !Empty:
  - Char = mem[rp+po]; New = 1; Count is unchanged.
  - If po == Count-1: po = 0 and Wrap = 1. Otherwise po++.
- NextChar while Empty, either mode: New = 0 and Char holds. There is no write-to-read bypass.
- Simultaneous LoadChar and NextChar:
  - Consume mode: both take effect, Count unchanged. If Empty, only the write takes effect.
  - Loop mode: the append takes effect. The wrap test uses the pre-write Count, so the new character plays on the next pass.
- Loop 1→0 mid-message: po returns to 0. The next consume read returns mem[rp], i.e. the oldest character.
- New and Wrap are 0 in every cycle without a qualifying read.

## Timing
- All outputs are registered.
- Char, New and Wrap update on the edge that samples NextChar (one-cycle latency).
- Count, Full and Empty reflect a write or read on the following cycle.
- Overflow asserts on the edge sampling a dropped LoadChar and stays high until Reset or Clear.
- Back-to-back NextChar every cycle is supported: one character per cycle.
- Back-to-back LoadChar every cycle is supported until Full.

## Structure
- Package pov_char_pkg holds:
  - CHAR_W_DEFAULT = 7
  - ASCII_SPACE = 7'h20
  - a char_t typedef
- Sub-module char_ram: DEPTH×CHAR_W register array with synchronous write and asynchronous read, parametrised by CHAR_W and DEPTH.
- Pointer, count, mode and flag logic live in pov_char_buffer.

## Test plan
- Reset and empty request: NextChar with nothing stored -> New stays 0, Char = 0, Empty = 1, Count = 0.
- Consume order: write 'H','I' (7'h48, 7'h49), then two NextChar, Loop = 0 -> Char 7'h48 then 7'h49, New pulses twice, Count 2→0, Empty = 1.
- Overflow: DEPTH = 4, write 5 chars -> Full = 1 after 4; 5th dropped; Overflow = 1 until Clear; Clear -> Count = 0, Overflow = 0.
- Loop replay: store 'A','B','C' (7'h41–7'h43), Loop = 1, six NextChar -> A,B,C,A,B,C; Wrap pulses with each C; Count stays 3.
- Simultaneous events: consume mode with Count = 2, LoadChar + NextChar in the same cycle -> Count stays 2 and Char = oldest entry. Full + LoadChar + NextChar -> write dropped, Overflow = 1, Count = DEPTH-1.
- Mode switch and reset mid-play: loop playing at po = 2, drop Loop -> next read returns the oldest character. Assert Reset mid-stream -> all outputs return to reset values on the next edge.
